wb_queue: RTL and testbench

Writeback queue that sits in front of the register file's single write port and feeds it. It accepts register writes from two producers: the single-cycle ALU path and the multi-cycle MUL/DIV unit. Accepted writes are buffered in order and retired one per cycle onto the register file write port. It also gives the decode stage a pending-write scoreboard and newest-value bypass lookups for both read ports.

---
 rtl/wb_queue_pkg.sv | 18 +
 rtl/wb_lookup.sv | 30 +++
 rtl/wb_queue.sv | 100 ++++++++++
 tb/tb_wb_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// Shared writeback types: queue entry layout, register bitmap and default sizes.
package wb_queue_pkg;

   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned WB_XLEN  = 64;

   typedef logic [31:0] regs_t;

   typedef struct packed {
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

   function automatic regs_t reg_onehot(input logic [4:0] r);
      return regs_t'(1) << r;
   endfunction

endpackage

// File: rtl/wb_lookup.sv
// Newest-match search over the occupied part of the writeback ring, walked from head by age.
module wb_lookup
   import wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  wb_entry_t [DEPTH-1:0] entries,
   input  logic [PTR_W-1:0]      head,
   input  logic [CNT_W-1:0]      count,
   input  logic [4:0]            look_reg,
   output logic                  hit,
   output logic [WB_XLEN-1:0]    data
);

   always_comb begin
      hit  = 1'b0;
      data = '0;
      // Oldest first, so the last match seen is the newest one.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count && look_reg != 5'd0 &&
             entries[head + PTR_W'(i)].rd == look_reg) begin
            hit  = 1'b1;
            data = entries[head + PTR_W'(i)].data;
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Two-producer writeback queue feeding the single register file write port, with
// busy scoreboard and bypass lookups. XLEN must match the package entry width.
module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH,
   parameter int unsigned XLEN  = WB_XLEN,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [4:0]       alu_reg,
   input  logic [XLEN-1:0]  alu_data,
   input  logic             mdu_valid,
   output logic             mdu_ready,
   input  logic [4:0]       mdu_reg,
   input  logic [XLEN-1:0]  mdu_data,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   input  logic [4:0]       look_reg1,
   input  logic [4:0]       look_reg2,
   output logic             look_hit1,
   output logic             look_hit2,
   output logic [XLEN-1:0]  look_data1,
   output logic [XLEN-1:0]  look_data2,
   output regs_t            busy,
   output logic [CNT_W-1:0] count
);

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]      head_q, tail_q, alu_slot;
   logic [CNT_W-1:0]      count_q, count_d, free;
   logic                  pop, mdu_acc, alu_acc, mdu_store, alu_store;

   assign pop  = count_q != '0;
   assign free = CNT_W'(DEPTH) - count_q + CNT_W'(pop);

   // MDU is older, so the ALU only gets a slot left over after the MDU takes one.
   assign mdu_ready = free != '0;
   assign mdu_acc   = mdu_valid && mdu_ready;
   assign alu_ready = mdu_acc ? (free >= CNT_W'(2)) : (free != '0);
   assign alu_acc   = alu_valid && alu_ready;

   // x0 writes are acknowledged but dropped.
   assign mdu_store = mdu_acc && mdu_reg != 5'd0;
   assign alu_store = alu_acc && alu_reg != 5'd0;
   assign alu_slot  = tail_q + PTR_W'(mdu_store);

   assign count_d = count_q - CNT_W'(pop) + CNT_W'(mdu_store) + CNT_W'(alu_store);

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PTR_W'(pop);
         tail_q  <= tail_q + PTR_W'(mdu_store) + PTR_W'(alu_store);
         count_q <= count_d;
         if (mdu_store) mem_q[tail_q] <= '{rd: mdu_reg, data: mdu_data};
         if (alu_store) mem_q[alu_slot] <= '{rd: alu_reg, data: alu_data};
      end
   end

   // Suppress the write during a reset cycle so discarded entries never land.
   assign rf_we    = pop && !reset;
   assign rf_waddr = rf_we ? mem_q[head_q].rd : 5'd0;
   assign rf_wdata = rf_we ? mem_q[head_q].data : '0;
   assign count    = count_q;

   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q) busy = busy | reg_onehot(mem_q[head_q + PTR_W'(i)].rd);
      end
   end

   wb_lookup #(.DEPTH(DEPTH)) u_look1 (
      .entries  (mem_q),
      .head     (head_q),
      .count    (count_q),
      .look_reg (look_reg1),
      .hit      (look_hit1),
      .data     (look_data1)
   );

   wb_lookup #(.DEPTH(DEPTH)) u_look2 (
      .entries  (mem_q),
      .head     (head_q),
      .count    (count_q),
      .look_reg (look_reg2),
      .hit      (look_hit2),
      .data     (look_data2)
   );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_wb_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 64;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk, reset;
   logic            alu_valid, alu_ready, mdu_valid, mdu_ready;
   logic [4:0]      alu_reg, mdu_reg, rf_waddr, look_reg1, look_reg2;
   logic [XLEN-1:0] alu_data, mdu_data, rf_wdata, look_data1, look_data2;
   logic            rf_we, look_hit1, look_hit2;
   logic [31:0]     busy;
   logic [CW-1:0]   count;

   wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_reg    (alu_reg),
      .alu_data   (alu_data),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_reg    (mdu_reg),
      .mdu_data   (mdu_data),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .look_reg1  (look_reg1),
      .look_reg2  (look_reg2),
      .look_hit1  (look_hit1),
      .look_hit2  (look_hit2),
      .look_data1 (look_data1),
      .look_data2 (look_data2),
      .busy       (busy),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   model_ok = 1'b0;
   bit   acc_m, acc_a;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: expected outputs from the model queue plus current inputs.
   always begin
      int          n, free;
      bit          em, ea, hit1, hit2, we;
      logic [63:0] d1, d2;
      logic [31:0] bz;
      @(negedge clk);
      #1;
      if (model_ok) begin
         n    = q.size();
         free = DEPTH - n + ((n > 0) ? 1 : 0);
         em   = free >= 1;
         acc_m = mdu_valid && em;
         ea   = free >= 1 + (acc_m ? 1 : 0);
         acc_a = alu_valid && ea;
         we   = (n > 0) && !reset;
         bz   = '0;
         hit1 = 1'b0; hit2 = 1'b0; d1 = '0; d2 = '0;
         foreach (q[i]) bz[q[i].rd] = 1'b1;
         for (int i = n - 1; i >= 0; i--) begin
            if (!hit1 && look_reg1 != 0 && q[i].rd == look_reg1) begin
               hit1 = 1'b1; d1 = q[i].data;
            end
            if (!hit2 && look_reg2 != 0 && q[i].rd == look_reg2) begin
               hit2 = 1'b1; d2 = q[i].data;
            end
         end
         chk("m_mdu_ready", 64'(mdu_ready), 64'(em));
         chk("m_alu_ready", 64'(alu_ready), 64'(ea));
         chk("m_rf_we", 64'(rf_we), 64'(we));
         chk("m_rf_waddr", 64'(rf_waddr), we ? 64'(q[0].rd) : 64'd0);
         chk("m_rf_wdata", rf_wdata, we ? q[0].data : 64'd0);
         chk("m_hit1", 64'(look_hit1), 64'(hit1));
         chk("m_data1", look_data1, d1);
         chk("m_hit2", 64'(look_hit2), 64'(hit2));
         chk("m_data2", look_data2, d2);
         chk("m_busy", 64'(busy), 64'(bz));
         chk("m_count", 64'(count), 64'(n));
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (q.size() > 0) void'(q.pop_front());
         if (acc_m && mdu_reg != 0) q.push_back('{rd: mdu_reg, data: mdu_data});
         if (acc_a && alu_reg != 0) q.push_back('{rd: alu_reg, data: alu_data});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mdu_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      alu_reg = '0; mdu_reg = '0; alu_data = '0; mdu_data = '0;
      look_reg1 = '0; look_reg2 = '0;
      repeat (2) cyc();
      reset = 1'b0;
      at_neg();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd1);
      chk("rst_mdu_ready", 64'(mdu_ready), 64'd1);
      chk("rst_hit1", 64'(look_hit1), 64'd0);

      // Single ALU write
      cyc();
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 64'h1234;
      at_neg();
      chk("single_ready", 64'(alu_ready), 64'd1);
      cyc();
      idle();
      at_neg();
      chk("single_we", 64'(rf_we), 64'd1);
      chk("single_waddr", 64'(rf_waddr), 64'd5);
      chk("single_wdata", rf_wdata, 64'h1234);
      chk("single_busy", 64'(busy), 64'h20);
      cyc();
      at_neg();
      chk("single_busy_clr", 64'(busy), 64'd0);
      chk("single_we_clr", 64'(rf_we), 64'd0);

      // Simultaneous MDU and ALU to the same register
      cyc();
      mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 64'hAA;
      alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 64'hBB;
      look_reg1 = 5'd7;
      cyc();
      idle();
      at_neg();
      chk("sim_count2", 64'(count), 64'd2);
      chk("sim_first", rf_wdata, 64'hAA);
      chk("sim_look_both", look_data1, 64'hBB);
      chk("sim_hit_both", 64'(look_hit1), 64'd1);
      cyc();
      at_neg();
      chk("sim_second", rf_wdata, 64'hBB);
      chk("sim_look_after", look_data1, 64'hBB);
      cyc();
      at_neg();
      chk("sim_empty_hit", 64'(look_hit1), 64'd0);

      // x0 write and lookup miss
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 64'hFF;
      look_reg1 = 5'd0; look_reg2 = 5'd9;
      at_neg();
      chk("x0_ready", 64'(alu_ready), 64'd1);
      cyc();
      idle();
      at_neg();
      chk("x0_count", 64'(count), 64'd0);
      chk("x0_we", 64'(rf_we), 64'd0);
      chk("x0_hit1", 64'(look_hit1), 64'd0);
      chk("miss_hit2", 64'(look_hit2), 64'd0);
      chk("miss_data2", look_data2, 64'd0);

      // Fill with both producers every cycle
      for (int c = 0; c < 6; c++) begin
         cyc();
         mdu_valid = 1'b1; mdu_reg = 5'(1 + 2 * c); mdu_data = {$urandom, $urandom};
         alu_valid = 1'b1; alu_reg = 5'(2 + 2 * c); alu_data = {$urandom, $urandom};
         look_reg1 = 5'(1 + 2 * c);
         at_neg();
         if (c >= 1) chk("fill_we", 64'(rf_we), 64'd1);
         if (c == 3) begin
            chk("fill_count", 64'(count), 64'd4);
            chk("fill_alu_ready", 64'(alu_ready), 64'd0);
            chk("fill_mdu_ready", 64'(mdu_ready), 64'd1);
         end
      end
      cyc();
      idle();
      repeat (6) cyc();

      // Reset mid-stream with three queued entries
      for (int c = 0; c < 2; c++) begin
         mdu_valid = 1'b1; mdu_reg = 5'(10 + c); mdu_data = 64'hD0 + 64'(2 * c);
         alu_valid = 1'b1; alu_reg = 5'(20 + c); alu_data = 64'hD1 + 64'(2 * c);
         cyc();
      end
      idle();
      reset = 1'b1;
      at_neg();
      chk("mid_count3", 64'(count), 64'd3);
      chk("mid_we_in_reset", 64'(rf_we), 64'd0);
      cyc();
      reset = 1'b0;
      at_neg();
      chk("mid_count0", 64'(count), 64'd0);
      chk("mid_busy0", 64'(busy), 64'd0);
      for (int c = 0; c < 3; c++) begin
         chk("mid_no_write", 64'(rf_we), 64'd0);
         at_neg();
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         cyc();
         reset     = ($urandom_range(0, 99) == 0);
         mdu_valid = ($urandom_range(0, 2) == 0);
         alu_valid = ($urandom_range(0, 3) != 0);
         mdu_reg   = 5'($urandom_range(0, 7));
         alu_reg   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 7));
         mdu_data  = {$urandom, $urandom};
         alu_data  = {$urandom, $urandom};
         look_reg1 = 5'($urandom_range(0, 8));
         look_reg2 = 5'($urandom_range(0, 8));
      end
      cyc();
      reset = 1'b0;
      idle();
      repeat (2) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
